// File: rtl/robo_pkg.sv
// Shared definitions for the robo_seguidor_param wall-following controller:
// state encoding, turn-direction codes and the counter width helper.
package robo_pkg;

  // State codes are also driven straight onto the estado output.
  typedef enum logic [1:0] {
    PARADO = 2'b00,
    SEGUE  = 2'b01,
    BUSCA  = 2'b10,
    GIRA   = 2'b11
  } estado_t;

  // girar_dir values: turn away from the followed wall / toward it.
  localparam logic GIRA_LONGE = 1'b0;
  localparam logic GIRA_PERTO = 1'b1;

  // Bits needed for a counter that has to hold values 0..v.
  function automatic int cnt_width(input int v);
    return $clog2(v + 1);
  endfunction

endpackage

// File: rtl/robo_debounce.sv
// One sensor input path: 2-FF synchroniser followed by a filter that only
// lets the filtered value follow the synced value after DEB_CYCLES
// consecutive differing edges. Shorter glitches never reach filt_o.
module robo_debounce
  import robo_pkg::*;
#(
  parameter int DEB_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,     // synchronous, active-low
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Filter: count differing edges, update filtered value on the last one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = {CW{1'b0}};
    if (sync2_q != filt_q) begin
      if (cnt_q >= CNT_LAST) begin
        filt_d = sync2_q;
        cnt_d  = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Synchroniser and filter state registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/robo_seguidor_param.sv
// Wall-following robot controller: debounced head/left/right sensors drive
// a PARADO/SEGUE/BUSCA/GIRA state machine with a minimum turn duration.
// All outputs are registered together with the state they describe.
// Optional build macro ROBO_SEARCH_TIMEOUT_EN: after SEARCH_LIMIT cycles in
// BUSCA without head or wall, force a turn toward the wall (girar_dir=1).
module robo_seguidor_param
  import robo_pkg::*;
#(
  parameter int DEB_CYCLES   = 2,
  parameter int TURN_CYCLES  = 4,
  parameter int SEARCH_LIMIT = 8
) (
  input  logic       clock,
  input  logic       reset,      // synchronous, active-low
  input  logic       en,
  input  logic       lado,
  input  logic       head,
  input  logic       left,
  input  logic       right,
  output logic       avancar,
  output logic       girar,
  output logic       girar_dir,
  output logic [1:0] estado
);

  // Parameters below 1 have no meaningful behaviour; this block only
  // flags such a configuration in the elaborated hierarchy.
  if (DEB_CYCLES < 1 || TURN_CYCLES < 1 || SEARCH_LIMIT < 1) begin : g_param_out_of_range
  end

  localparam int TW = cnt_width(TURN_CYCLES);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);

  logic head_f;
  logic left_f;
  logic right_f;
  logic wall_s;

  estado_t       state_q;
  estado_t       state_d;
  logic          avancar_q;
  logic          avancar_d;
  logic          girar_q;
  logic          girar_d;
  logic          dir_q;
  logic          dir_d;
  logic          lado_q;
  logic          lado_d;
  logic [TW-1:0] turn_q;
  logic [TW-1:0] turn_d;

`ifdef ROBO_SEARCH_TIMEOUT_EN
  localparam int SW = cnt_width(SEARCH_LIMIT);
  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_LIMIT - 1);
  logic [SW-1:0] search_q;
  logic [SW-1:0] search_d;
`endif

  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_head (
    .clock (clock), .reset (reset), .raw_i (head),  .filt_o (head_f)
  );
  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clock (clock), .reset (reset), .raw_i (left),  .filt_o (left_f)
  );
  robo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clock (clock), .reset (reset), .raw_i (right), .filt_o (right_f)
  );

  assign wall_s = lado_q ? right_f : left_f;

  // Next state and next registered outputs; en=0 overrides everything.
  always_comb begin
    state_d   = state_q;
    avancar_d = 1'b0;
    girar_d   = 1'b0;
    dir_d     = GIRA_LONGE;
    lado_d    = lado_q;
    turn_d    = turn_q;
`ifdef ROBO_SEARCH_TIMEOUT_EN
    search_d  = search_q;
`endif
    if (!en) begin
      state_d = PARADO;
      turn_d  = {TW{1'b0}};
    end else begin
      case (state_q)
        PARADO: begin
          lado_d    = lado;
          state_d   = SEGUE;
          avancar_d = 1'b1;
          turn_d    = {TW{1'b0}};
        end
        SEGUE: begin
          if (head_f) begin
            state_d = GIRA;
            girar_d = 1'b1;
            dir_d   = GIRA_LONGE;
            turn_d  = TURN_LOAD;
          end else if (wall_s) begin
            avancar_d = 1'b1;
          end else begin
            state_d   = BUSCA;
            avancar_d = 1'b1;
`ifdef ROBO_SEARCH_TIMEOUT_EN
            search_d  = {SW{1'b0}};
`endif
          end
        end
        BUSCA: begin
          if (head_f) begin
            state_d = GIRA;
            girar_d = 1'b1;
            dir_d   = GIRA_LONGE;
            turn_d  = TURN_LOAD;
          end else if (wall_s) begin
            state_d   = SEGUE;
            avancar_d = 1'b1;
          end else begin
`ifdef ROBO_SEARCH_TIMEOUT_EN
            if (search_q >= SEARCH_LAST) begin
              state_d = GIRA;
              girar_d = 1'b1;
              dir_d   = GIRA_PERTO;
              turn_d  = TURN_LOAD;
            end else begin
              avancar_d = 1'b1;
              search_d  = search_q + SW'(1);
            end
`else
            avancar_d = 1'b1;
`endif
          end
        end
        GIRA: begin
          if ((turn_q == {TW{1'b0}}) && !head_f) begin
            state_d   = SEGUE;
            avancar_d = 1'b1;
          end else begin
            girar_d = 1'b1;
            dir_d   = dir_q;
            if (turn_q != {TW{1'b0}}) begin
              turn_d = turn_q - TW'(1);
            end else begin
              turn_d = {TW{1'b0}};
            end
          end
        end
        default: begin
          state_d = PARADO;
          turn_d  = {TW{1'b0}};
        end
      endcase
    end
  end

  // State, output and counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= PARADO;
      avancar_q <= 1'b0;
      girar_q   <= 1'b0;
      dir_q     <= GIRA_LONGE;
      lado_q    <= 1'b0;
      turn_q    <= {TW{1'b0}};
    end else begin
      state_q   <= state_d;
      avancar_q <= avancar_d;
      girar_q   <= girar_d;
      dir_q     <= dir_d;
      lado_q    <= lado_d;
      turn_q    <= turn_d;
    end
  end

`ifdef ROBO_SEARCH_TIMEOUT_EN
  // Search duration counter, only present with the timeout feature.
  always_ff @(posedge clock) begin
    if (!reset) begin
      search_q <= {SW{1'b0}};
    end else begin
      search_q <= search_d;
    end
  end
`endif

  assign avancar   = avancar_q;
  assign girar     = girar_q;
  assign girar_dir = dir_q;
  assign estado    = state_q;

endmodule

// File: tb/tb_robo_seguidor_param.sv
// Self-checking bench for robo_seguidor_param: directed scenarios followed by
// random sensor/enable/reset activity, compared every cycle against a
// behavioural model built from sample histories and elapsed-cycle counts.
module tb_robo_seguidor_param;

  localparam int DEB   = 2;
  localparam int TURN  = 4;
  localparam int LIMIT = 8;
`ifdef ROBO_SEARCH_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       lado  = 1'b0;
  logic       head  = 1'b0;
  logic       left  = 1'b0;
  logic       right = 1'b0;
  logic       avancar;
  logic       girar;
  logic       girar_dir;
  logic [1:0] estado;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  robo_seguidor_param #(
    .DEB_CYCLES  (DEB),
    .TURN_CYCLES (TURN),
    .SEARCH_LIMIT(LIMIT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .lado      (lado),
    .head      (head),
    .left      (left),
    .right     (right),
    .avancar   (avancar),
    .girar     (girar),
    .girar_dir (girar_dir),
    .estado    (estado)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 stopped, 1 following, 2 searching, 3 turning.
  bit       m_s1 [3];
  bit       m_s2 [3];
  bit       m_f  [3];
  bit       m_hist [3][DEB];
  logic [1:0] m_mode;
  bit       m_av, m_gi, m_dir, m_lado;
  int       turn_age, search_age;
  int       gi_count, dir_count;

  task automatic model_turn(input bit toward);
    m_mode   = 2'd3;
    m_av     = 1'b0;
    m_gi     = 1'b1;
    m_dir    = toward;
    turn_age = 1;
  endtask

  task automatic model_step();
    bit raw [3];
    bit hd, wall, all_diff;
    raw[0] = head; raw[1] = left; raw[2] = right;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_f[i] = 1'b0;
        for (int j = 0; j < DEB; j++) m_hist[i][j] = 1'b0;
      end
      m_mode = 2'd0; m_av = 1'b0; m_gi = 1'b0; m_dir = 1'b0; m_lado = 1'b0;
      turn_age = 0; search_age = 0;
      return;
    end
    hd   = m_f[0];
    wall = m_lado ? m_f[2] : m_f[1];
    if (!en) begin
      m_mode = 2'd0; m_av = 1'b0; m_gi = 1'b0; m_dir = 1'b0;
    end else begin
      case (m_mode)
        2'd0: begin
          m_lado = lado; m_mode = 2'd1; m_av = 1'b1; m_gi = 1'b0; m_dir = 1'b0;
        end
        2'd1: begin
          if (hd) model_turn(1'b0);
          else begin
            m_av = 1'b1; m_gi = 1'b0; m_dir = 1'b0;
            if (!wall) begin m_mode = 2'd2; search_age = 1; end
          end
        end
        2'd2: begin
          if (hd) model_turn(1'b0);
          else if (wall) begin m_mode = 2'd1; m_av = 1'b1; m_gi = 1'b0; m_dir = 1'b0; end
          else if (TIMEOUT && search_age >= LIMIT) model_turn(1'b1);
          else begin m_av = 1'b1; m_gi = 1'b0; m_dir = 1'b0; search_age++; end
        end
        default: begin
          if (turn_age >= TURN && !hd) begin
            m_mode = 2'd1; m_av = 1'b1; m_gi = 1'b0; m_dir = 1'b0;
          end else begin
            turn_age++;
          end
        end
      endcase
    end
    // Filtered value flips once the last DEB synced samples all disagree with it.
    for (int i = 0; i < 3; i++) begin
      for (int j = DEB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
      m_hist[i][0] = m_s2[i];
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) if (m_hist[i][j] == m_f[i]) all_diff = 1'b0;
      if (all_diff) m_f[i] = ~m_f[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  // One clock: model update at the edge, compare 1 time unit later,
  // return at the falling edge so the caller can drive new inputs.
  task automatic tick(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check_val(tag, {27'd0, avancar, girar, girar_dir, estado},
                   {27'd0, m_av, m_gi, m_dir, m_mode});
    if (girar)     gi_count++;
    if (girar_dir) dir_count++;
    @(negedge clock);
  endtask

  initial begin
    // Reset
    reset = 1'b0;
    repeat (3) tick("reset");
    check_val("reset_estado", {30'd0, estado}, 32'd0);

    // Start following the left wall
    reset = 1'b1; en = 1'b1; left = 1'b1; lado = 1'b0; head = 1'b0;
    repeat (8) tick("segue_start");
    check_val("segue_estado", {30'd0, estado}, 32'd1);
    check_val("segue_avancar", {31'd0, avancar}, 32'd1);

    // One-cycle head glitch must not turn
    gi_count = 0;
    head = 1'b1; tick("glitch");
    head = 1'b0;
    repeat (6) tick("glitch");
    check_val("glitch_girar_cycles", gi_count, 32'd0);

    // Short head pulse: minimum turn length
    gi_count = 0;
    head = 1'b1; repeat (3) tick("turn_min");
    head = 1'b0; repeat (12) tick("turn_min");
    check_val("turn_min_cycles", gi_count, TURN);
    check_val("turn_min_back", {30'd0, estado}, 32'd1);

    // Long head pulse: turn extends
    gi_count = 0;
    head = 1'b1; repeat (10) tick("turn_long");
    head = 1'b0; repeat (12) tick("turn_long");
    check_val("turn_long_cycles", gi_count, 32'd10);

    // Right-wall following with no right wall: search
    en = 1'b0; tick("busca");
    lado = 1'b1; right = 1'b0; left = 1'b1; en = 1'b1;
    dir_count = 0;
    repeat (12) tick("busca");
    check_val("busca_dir_seen", {31'd0, (dir_count > 0)}, {31'd0, TIMEOUT});
    if (!TIMEOUT) check_val("busca_stays", {30'd0, estado}, 32'd2);

    // Abort a turn with en=0, then reset from a turn
    lado = 1'b0; right = 1'b1;
    repeat (6) tick("recover");
    head = 1'b1; repeat (5) tick("pre_abort");
    en = 1'b0; tick("en_abort");
    check_val("abort_outputs", {28'd0, avancar, girar, estado}, 32'd0);
    en = 1'b1; repeat (5) tick("pre_reset");
    reset = 1'b0; tick("reset_gira");
    check_val("reset_gira_outputs", {27'd0, avancar, girar, girar_dir, estado}, 32'd0);
    reset = 1'b1; head = 1'b0;

    // Random activity
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0)   head  = ~head;
      if ($urandom_range(0, 7) == 0)   left  = ~left;
      if ($urandom_range(0, 7) == 0)   right = ~right;
      if ($urandom_range(0, 40) == 0)  lado  = ~lado;
      if ($urandom_range(0, 60) == 0)  en    = ~en;
      reset = ($urandom_range(0, 299) != 0);
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/robo_seguidor_param.md
Name: robo_seguidor_param

Overview:
Parametrised wall-following controller, successor to the two-state robot FSM. It adds:
- per-sensor synchroniser and debounce filters
- selectable wall side (left/right)
- an explicit stopped state under enable
- a minimum turn duration
Sits between the raw obstacle sensors and the motor driver (avancar/girar). Registered outputs, single clock domain.

Parameters:
DEB_CYCLES, 2, consecutive stable cycles before a filtered sensor changes (>=1)
TURN_CYCLES, 4, minimum cycles girar stays high per turn (>=1)
SEARCH_LIMIT, 8, BUSCA cycles before forced turn toward wall; used only with ROBO_SEARCH_TIMEOUT_EN (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
en  in  1  run enable; 0 forces PARADO
lado  in  1  followed wall: 0 left, 1 right; latched on PARADO exit
head  in  1  raw front obstacle sensor, asynchronous
left  in  1  raw left wall sensor, asynchronous
right  in  1  raw right wall sensor, asynchronous
avancar  out  1  drive forward
girar  out  1  rotate
girar_dir  out  1  0 = turn away from wall, 1 = turn toward wall
estado  out  2  current state code

Behaviour:
Reset (reset=0 at an edge):
- state PARADO
- avancar, girar, girar_dir = 0; estado = 2'b00
- sync flops, filtered sensors, all counters and the lado latch = 0

Sensor path, per sensor:
- 2-FF synchroniser, then filter counter.
- Counter increments each edge where the synced value != filtered value; it clears when they are equal.
- Filtered value takes the synced value on the DEB_CYCLES-th consecutive differing edge.
- A stable raw change sampled at edge 1 appears on avancar/girar at edge DEB_CYCLES+3.
- Glitches shorter than DEB_CYCLES cycles are rejected.

wall = filtered left if lado_latched=0, else filtered right.

States (estado code):
- PARADO (00): outputs 0. en=1 -> latch lado, go to SEGUE.
- SEGUE (01):
  - head=1 -> GIRA, girar_dir=0
  - else wall=1 -> stay, avancar=1
  - else -> BUSCA, avancar=1
- BUSCA (10):
  - head=1 -> GIRA, girar_dir=0
  - else wall=1 -> SEGUE, avancar=1
  - else -> stay, avancar=1
- GIRA (11):
  - girar=1, avancar=0
  - On entry, turn counter loads TURN_CYCLES-1 and decrements each cycle.
  - Exit to SEGUE (avancar=1) when counter==0 and head=0; otherwise stay (turn extends while head=1).

Output timing:
- Outputs and estado are registered on the same edge as the state they describe, so they reflect the state being entered.
- avancar and girar are never both 1.

Priority: reset > en=0 > head > wall > default. en=0 in any state -> PARADO at the next edge and aborts any turn; the turn counter clears.

lado changes outside PARADO are ignored until the next PARADO exit.

Counter widths: $clog2(param+1); no wrap. Each counter saturates at its terminal value.

Optional Feature:
Macro ROBO_SEARCH_TIMEOUT_EN.
- Defined:
  - A search counter clears on BUSCA entry and increments each BUSCA cycle.
  - On reaching SEARCH_LIMIT with head=0 and wall=0 -> GIRA with girar_dir=1.
  - head/wall conditions in the same cycle take priority over the timeout.
- Undefined: BUSCA may last indefinitely; girar_dir is always 0; SEARCH_LIMIT is unused and no counter logic is generated.

Decomposition:
Package robo_pkg holds:
- state enum (PARADO, SEGUE, BUSCA, GIRA with the codes above)
- GIRA_LONGE=0 and GIRA_PERTO=1 constants
- the $clog2 width helper

One sub-module, robo_debounce (parameter DEB_CYCLES, synchroniser plus filter), is instantiated three times.

Test Plan (DEB=2, TURN=4, LIMIT=8):
- Reset then en=1, left=1, head=0, lado=0 -> PARADO, then SEGUE (estado 01) with avancar=1 steady.
- In SEGUE, 1-cycle head pulse -> filtered out; no change on girar.
- In SEGUE, head=1 held 3 cycles then 0 -> girar=1 for exactly 4 cycles, girar_dir=0, then SEGUE.
- head=1 held 10 cycles -> girar stays 1 until head clears through the filter, then SEGUE.
- lado=1, right=0, left=1 -> BUSCA; with ROBO_SEARCH_TIMEOUT_EN, after 8 cycles GIRA with girar_dir=1. Without the macro, stays in BUSCA.
- en=0 mid-GIRA -> PARADO at next edge, all outputs 0. Also check reset=0 from any state -> PARADO at next edge.
